lector_7segmentos: RTL and testbench
====================================

# lector_7segmentos

Scan reader for the multiplexed 7-segment display bus. It samples the segment lines and the digit-enable lines that the display driver produces, rebuilds the four per-digit patterns, and decodes each pattern back to a hex code. It also flags scan faults. It sits on the board-side end of the display interface and is used for self-check and loopback verification of the display path.

## Interface
Parameters:
- STABLE_SAMPLES, 4: consecutive identical synchronized samples needed to accept a digit (range 2..15).
- SCAN_TIMEOUT, 1024: cycles allowed without a complete frame before a fault is raised (range 16..65535).

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- SEGMENTOS  in  8  segment bus, active-low; [6:0] = g..a, [7] = dp.
- DISPLAY  in  4  digit enables, active-low; bit i low selects digit i.
- CLR  in  1  clears ERROR_SCAN.
- PATRON  out  32  last complete frame of raw patterns; digit i in [8i+7:8i].
- CODIGO  out  16  decoded 4-bit code per digit; digit i in [4i+3:4i].
- VALIDO  out  4  bit i = digit i pattern matched a hex glyph.
- PUNTOS  out  4  dp state per digit (1 = lit).
- TRAMA_OK  out  1  one-cycle pulse when PATRON, CODIGO, VALIDO and PUNTOS update.
- ERROR_SCAN  out  1  sticky scan fault.

## Operation
- **Synchronizer:** SEGMENTOS and DISPLAY pass through two flip-flop stages before any use.
- **Stability counter:** a 4-bit counter compares the current synchronized sample with the previous one.
  - If the sample is equal, the counter increments and saturates at STABLE_SAMPLES.
  - If the sample differs, the counter loads 1.
- **FSM states:** ESPERA, ACEPTADO, CONFLICTO.
  - ESPERA → ACEPTADO: counter reaches STABLE_SAMPLES and exactly one DISPLAY bit is low. In that cycle the pattern is written into shadow slot i and capture-mask bit i is set.
  - ESPERA → CONFLICTO: counter reaches STABLE_SAMPLES and two or more DISPLAY bits are low. ERROR_SCAN is set.
  - ESPERA stays in ESPERA when all DISPLAY bits are high (blanking interval). Nothing is captured.
  - ACEPTADO or CONFLICTO → ESPERA: the sample changes. A run is accepted only once.
- **Re-capture:** if a digit is captured again before the frame completes, its shadow slot is overwritten.
- **Frame complete:** when the capture mask equals 4'b1111:
  - shadows are copied to the outputs atomically;
  - TRAMA_OK pulses;
  - the mask and the timeout counter clear.
- **Decode:** uses [6:0] only. Active-low glyphs 0..F are 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Any other pattern, including blank 7F, gives CODIGO = 0 and VALIDO = 0.
- **Timeout:** a 16-bit counter increments every cycle without a frame. Reaching SCAN_TIMEOUT sets ERROR_SCAN and restarts the count.

## Timing
- Reset values:
  - PATRON = 32'hFFFF_FFFF
  - CODIGO = 0, VALIDO = 0, PUNTOS = 0
  - TRAMA_OK = 0, ERROR_SCAN = 0
  - FSM = ESPERA; mask, counters and synchronizers cleared (synchronizers load all-ones).
- **Digit acceptance latency:** a pin value stable from cycle t is accepted at the edge of cycle t+2+STABLE_SAMPLES−1.
- **Frame latency:** outputs and TRAMA_OK are updated on the edge after the fourth acceptance. They are registered and hold until the next frame.
- **Frame and timeout in the same cycle:** the frame wins; no error is raised and the timeout counter clears.
- **CLR and a new fault in the same cycle:** the set wins.
- **RST mid-frame:** the partial frame is discarded and the outputs return to reset values on the next edge.
- **Differing sample on the acceptance cycle:** no capture; the counter reloads 1.

## Configuration
- **LECTOR_DP_EN defined:**
  - bit 7 takes part in the stability compare;
  - it is captured into PATRON;
  - PUNTOS[i] = ~PATRON[8i+7].
- **LECTOR_DP_EN undefined:**
  - bit 7 is masked to 1 at the synchronizer output, so it is stored as 1 in PATRON;
  - it does not affect stability;
  - PUNTOS is held at 0.

## Test plan
- **Basic frame:** hold each digit 8 cycles with blanking between, digits 0..3 showing 40,79,24,30, STABLE_SAMPLES=4 → one TRAMA_OK pulse, CODIGO=16'h3210, VALIDO=4'hF.
- **Short hold:** digit 2 held only 3 cycles → no capture, no TRAMA_OK until digit 2 is held ≥4 cycles.
- **Unknown pattern:** digit 1 shows 7F, then 55, each held stable → CODIGO[7:4]=0 and VALIDO[1]=0 after the frame, in both cases.
- **Conflict and CLR:** DISPLAY=4'b1100 stable for 4 cycles → ERROR_SCAN=1 and stays 1 through a later good frame; CLR pulse → 0.
- **Timeout:** DISPLAY held at 4'hF for SCAN_TIMEOUT cycles → ERROR_SCAN=1 at exactly that cycle; RST mid-frame → all outputs at reset values on the next edge.
- **dp capture:** with LECTOR_DP_EN, digit 3 = 8'h40 → PUNTOS[3]=1; without the macro, the same stimulus → PUNTOS=0.

Source files
------------

// File: rtl/lector_7segmentos.sv
// Scan reader for a multiplexed 7-segment bus: rebuilds the four digit patterns and decodes them to hex.
// Optional macro LECTOR_DP_EN: the decimal point (bit 7) is tracked, captured and reported on PUNTOS.
module lector_7segmentos #(
  parameter int STABLE_SAMPLES = 4,
  parameter int SCAN_TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SEGMENTOS,
  input  logic [3:0]  DISPLAY,
  input  logic        CLR,
  output logic [31:0] PATRON,
  output logic [15:0] CODIGO,
  output logic [3:0]  VALIDO,
  output logic [3:0]  PUNTOS,
  output logic        TRAMA_OK,
  output logic        ERROR_SCAN
);

  typedef enum logic [1:0] {ESPERA, ACEPTADO, CONFLICTO} estado_t;

  localparam logic [3:0]  CNT_MAX = 4'(STABLE_SAMPLES);
  localparam logic [3:0]  CNT_PRE = 4'(STABLE_SAMPLES - 1);
  localparam logic [15:0] TO_LAST = 16'(SCAN_TIMEOUT - 1);

  logic [7:0]  r_segMeta;
  logic [7:0]  r_segSync;
  logic [3:0]  r_dispMeta;
  logic [3:0]  r_dispSync;
  logic [7:0]  w_seg;
  logic [11:0] w_sample;
  logic [11:0] r_prev;
  logic [3:0]  r_cnt;
  logic        w_equal;
  logic        w_reach;
  logic [2:0]  w_nLow;
  logic        w_capture;
  logic        w_conflict;
  logic        w_frame;
  logic        w_toHit;
  estado_t     r_estado;
  logic [7:0]  r_shadow [4];
  logic [3:0]  r_mask;
  logic [15:0] r_to;
  logic [31:0] r_patron;
  logic [15:0] r_codigo;
  logic [3:0]  r_valido;
  logic [3:0]  r_puntos;
  logic        r_trama;
  logic        r_error;

  // Returns {valid, code}; blank and non-glyph patterns decode to zero.
  function automatic logic [4:0] decodificar(input logic [6:0] p);
    logic [4:0] res;
    case (p)
      7'h40:   res = 5'h10;
      7'h79:   res = 5'h11;
      7'h24:   res = 5'h12;
      7'h30:   res = 5'h13;
      7'h19:   res = 5'h14;
      7'h12:   res = 5'h15;
      7'h02:   res = 5'h16;
      7'h78:   res = 5'h17;
      7'h00:   res = 5'h18;
      7'h10:   res = 5'h19;
      7'h08:   res = 5'h1A;
      7'h03:   res = 5'h1B;
      7'h46:   res = 5'h1C;
      7'h21:   res = 5'h1D;
      7'h06:   res = 5'h1E;
      7'h0E:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_segMeta  <= '1;
      r_segSync  <= '1;
      r_dispMeta <= '1;
      r_dispSync <= '1;
    end else begin
      r_segMeta  <= SEGMENTOS;
      r_segSync  <= r_segMeta;
      r_dispMeta <= DISPLAY;
      r_dispSync <= r_dispMeta;
    end
  end

`ifdef LECTOR_DP_EN
  assign w_seg = r_segSync;
`else
  // Without dp support bit 7 is forced high so it never disturbs stability.
  logic w_unusedDp;
  assign w_unusedDp = r_segSync[7];
  assign w_seg      = {1'b1, r_segSync[6:0]};
`endif

  assign w_sample   = {w_seg, r_dispSync};
  assign w_equal    = (w_sample == r_prev);
  assign w_reach    = w_equal && (r_cnt == CNT_PRE);
  assign w_nLow     = {2'b0, ~r_dispSync[0]} + {2'b0, ~r_dispSync[1]}
                    + {2'b0, ~r_dispSync[2]} + {2'b0, ~r_dispSync[3]};
  assign w_capture  = (r_estado == ESPERA) && w_reach && (w_nLow == 3'd1);
  assign w_conflict = (r_estado == ESPERA) && w_reach && (w_nLow >= 3'd2);
  assign w_frame    = (r_mask == 4'hF);
  assign w_toHit    = !w_frame && (r_to == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev <= '1;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_sample;
      if (!w_equal)
        r_cnt <= 4'd1;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 4'd1;
    end
  end

  // A run is judged once, when it first reaches the threshold; a new run must start to re-arm.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_estado <= ESPERA;
      r_mask   <= '0;
      for (int i = 0; i < 4; i++)
        r_shadow[i] <= '1;
    end else begin
      r_mask <= (w_frame ? 4'b0 : r_mask) | (w_capture ? ~r_dispSync : 4'b0);
      for (int i = 0; i < 4; i++)
        if (w_capture && !r_dispSync[i])
          r_shadow[i] <= w_seg;
      case (r_estado)
        ESPERA: begin
          if (w_capture)
            r_estado <= ACEPTADO;
          else if (w_conflict)
            r_estado <= CONFLICTO;
        end
        ACEPTADO, CONFLICTO: begin
          if (!w_equal)
            r_estado <= ESPERA;
        end
        default: r_estado <= ESPERA;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to    <= '0;
      r_error <= 1'b0;
    end else begin
      r_to <= (w_frame || w_toHit) ? 16'd0 : r_to + 16'd1;
      if (w_conflict || w_toHit)
        r_error <= 1'b1;
      else if (CLR)
        r_error <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_patron <= '1;
      r_codigo <= '0;
      r_valido <= '0;
      r_puntos <= '0;
      r_trama  <= 1'b0;
    end else begin
      r_trama <= w_frame;
      if (w_frame) begin
        for (int i = 0; i < 4; i++) begin
          r_patron[8*i +: 8]                  <= r_shadow[i];
          {r_valido[i], r_codigo[4*i +: 4]}   <= decodificar(r_shadow[i][6:0]);
`ifdef LECTOR_DP_EN
          r_puntos[i] <= ~r_shadow[i][7];
`else
          r_puntos[i] <= 1'b0;
`endif
        end
      end
    end
  end

  assign PATRON     = r_patron;
  assign CODIGO     = r_codigo;
  assign VALIDO     = r_valido;
  assign PUNTOS     = r_puntos;
  assign TRAMA_OK   = r_trama;
  assign ERROR_SCAN = r_error;

endmodule

// File: tb/tb_lector_7segmentos.sv
// Self-checking bench for lector_7segmentos: pin-history reference model plus directed and random scans.
module tb_lector_7segmentos;

  localparam int SS   = 4;
  localparam int TO   = 200;
  localparam int HIST = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  SEGMENTOS = 8'hFF;
  logic [3:0]  DISPLAY = 4'hF;
  logic        CLR = 1'b0;
  logic [31:0] PATRON;
  logic [15:0] CODIGO;
  logic [3:0]  VALIDO;
  logic [3:0]  PUNTOS;
  logic        TRAMA_OK;
  logic        ERROR_SCAN;

  int testsRun    = 0;
  int testsFailed = 0;
  int tramaCnt    = 0;
  bit checkEn     = 1'b0;

  logic [6:0]  glyphTab [16];
  logic [11:0] hist [HIST];
  logic [7:0]  mShadow [4];
  logic [3:0]  mMask;
  logic [31:0] mPatron;
  logic [15:0] mCodigo;
  logic [3:0]  mValido;
  logic [3:0]  mPuntos;
  logic        mTrama;
  logic        mError;
  int          mTo;

`ifdef LECTOR_DP_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  lector_7segmentos #(.STABLE_SAMPLES(SS), .SCAN_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .SEGMENTOS(SEGMENTOS), .DISPLAY(DISPLAY), .CLR(CLR),
    .PATRON(PATRON), .CODIGO(CODIGO), .VALIDO(VALIDO), .PUNTOS(PUNTOS),
    .TRAMA_OK(TRAMA_OK), .ERROR_SCAN(ERROR_SCAN)
  );

  always #5 CLK = ~CLK;

  initial begin
    glyphTab[0]  = 7'h40; glyphTab[1]  = 7'h79; glyphTab[2]  = 7'h24; glyphTab[3]  = 7'h30;
    glyphTab[4]  = 7'h19; glyphTab[5]  = 7'h12; glyphTab[6]  = 7'h02; glyphTab[7]  = 7'h78;
    glyphTab[8]  = 7'h00; glyphTab[9]  = 7'h10; glyphTab[10] = 7'h08; glyphTab[11] = 7'h03;
    glyphTab[12] = 7'h46; glyphTab[13] = 7'h21; glyphTab[14] = 7'h06; glyphTab[15] = 7'h0E;
  end

  function automatic logic [4:0] refDecode(input logic [6:0] p);
    logic [4:0] res;
    res = 5'b0;
    for (int g = 0; g < 16; g++)
      if (glyphTab[g] == p) res = {1'b1, 4'(g)};
    return res;
  endfunction

  // Reference: a digit is accepted when the pin value seen two edges ago has been identical for exactly SS edges.
  always @(posedge CLK) begin : refModel
    logic [7:0] segIn;
    logic [4:0] d;
    logic       frame, errSet, stable;
    int         lows, slot;
    segIn = SEGMENTOS;
    if (!DP) segIn[7] = 1'b1;
    if (RST) begin
      for (int j = 0; j < HIST; j++) hist[j] = 12'hFFF;
      for (int i = 0; i < 4; i++) mShadow[i] = 8'hFF;
      mMask = 4'h0; mPatron = 32'hFFFF_FFFF; mCodigo = 16'h0; mValido = 4'h0;
      mPuntos = 4'h0; mTrama = 1'b0; mError = 1'b0; mTo = 0;
    end else begin
      errSet = 1'b0;
      frame  = (mMask == 4'hF);
      mTrama = frame;
      if (frame) begin
        mMask = 4'h0;
        mTo   = 0;
        for (int i = 0; i < 4; i++) begin
          mPatron[8*i +: 8] = mShadow[i];
          d = refDecode(mShadow[i][6:0]);
          mValido[i] = d[4];
          mCodigo[4*i +: 4] = d[3:0];
          mPuntos[i] = DP ? ~mShadow[i][7] : 1'b0;
        end
      end else begin
        mTo++;
        if (mTo == TO) begin
          errSet = 1'b1;
          mTo = 0;
        end
      end
      for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {segIn, DISPLAY};
      stable = 1'b1;
      for (int k = 3; k <= SS + 1; k++)
        if (hist[k] != hist[2]) stable = 1'b0;
      if (hist[SS+2] == hist[2]) stable = 1'b0;
      if (stable) begin
        lows = 0;
        slot = 0;
        for (int i = 0; i < 4; i++)
          if (!hist[2][i]) begin
            lows++;
            slot = i;
          end
        if (lows == 1) begin
          mShadow[slot] = hist[2][11:4];
          mMask[slot] = 1'b1;
        end else if (lows >= 2) begin
          errSet = 1'b1;
        end
      end
      if (errSet) mError = 1'b1;
      else if (CLR) mError = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("PATRON", PATRON, mPatron);
      checkOutput("CODIGO", {16'h0, CODIGO}, {16'h0, mCodigo});
      checkOutput("VALIDO", {28'h0, VALIDO}, {28'h0, mValido});
      checkOutput("PUNTOS", {28'h0, PUNTOS}, {28'h0, mPuntos});
      checkOutput("TRAMA_OK", {31'h0, TRAMA_OK}, {31'h0, mTrama});
      checkOutput("ERROR_SCAN", {31'h0, ERROR_SCAN}, {31'h0, mError});
    end
  end

  always @(posedge CLK) begin
    #2;
    if (checkEn && TRAMA_OK === 1'b1) tramaCnt++;
  end

  task automatic applyStimulus(input logic [7:0] seg, input logic [3:0] disp, input int cycles);
    SEGMENTOS = seg;
    DISPLAY   = disp;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic sendDigit(input int i, input logic [7:0] seg, input int hold);
    applyStimulus(seg, ~(4'b1 << i), hold);
    applyStimulus(8'hFF, 4'hF, 3);
  endtask

  task automatic clrPulse();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " PATRON"}, PATRON, 32'hFFFF_FFFF);
    checkOutput({tag, " CODIGO"}, {16'h0, CODIGO}, 32'h0);
    checkOutput({tag, " VALIDO"}, {28'h0, VALIDO}, 32'h0);
    checkOutput({tag, " PUNTOS"}, {28'h0, PUNTOS}, 32'h0);
    checkOutput({tag, " TRAMA_OK"}, {31'h0, TRAMA_OK}, 32'h0);
    checkOutput({tag, " ERROR_SCAN"}, {31'h0, ERROR_SCAN}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    checkEn = 1'b1;
    checkResetValues("reset");

    // Basic frame: digits 0..3 show 0,1,2,3.
    sendDigit(0, 8'hC0, 8);
    sendDigit(1, 8'hF9, 8);
    sendDigit(2, 8'hA4, 8);
    sendDigit(3, 8'hB0, 8);
    checkOutput("basic trama count", tramaCnt, 1);
    checkOutput("basic CODIGO", {16'h0, CODIGO}, 32'h3210);
    checkOutput("basic VALIDO", {28'h0, VALIDO}, 32'hF);
    checkOutput("basic PATRON", PATRON, 32'hB0A4_F9C0);

    // Short hold on digit 2 must not capture.
    t0 = tramaCnt;
    sendDigit(0, 8'hC0, 8);
    sendDigit(1, 8'hF9, 8);
    sendDigit(2, 8'hA4, 3);
    sendDigit(3, 8'hB0, 8);
    checkOutput("short hold no frame", tramaCnt, t0);
    sendDigit(2, 8'hA4, 8);
    checkOutput("short hold then frame", tramaCnt, t0 + 1);

    // Unknown patterns on digit 1: blank, then 55.
    sendDigit(0, 8'hC0, 8);
    sendDigit(1, 8'hFF, 8);
    sendDigit(2, 8'hA4, 8);
    sendDigit(3, 8'hB0, 8);
    checkOutput("blank CODIGO", {16'h0, CODIGO}, 32'h3200);
    checkOutput("blank VALIDO", {28'h0, VALIDO}, 32'hD);
    sendDigit(1, 8'hD5, 8);
    sendDigit(0, 8'hC0, 8);
    sendDigit(2, 8'hA4, 8);
    sendDigit(3, 8'hB0, 8);
    checkOutput("55 CODIGO", {16'h0, CODIGO}, 32'h3200);
    checkOutput("55 VALIDO", {28'h0, VALIDO}, 32'hD);

    // Two digits enabled at once is a sticky fault until CLR.
    applyStimulus(8'hC0, 4'b1100, 6);
    applyStimulus(8'hFF, 4'hF, 3);
    checkOutput("conflict sets error", {31'h0, ERROR_SCAN}, 32'h1);
    sendDigit(0, 8'hC0, 8);
    sendDigit(1, 8'hF9, 8);
    sendDigit(2, 8'hA4, 8);
    sendDigit(3, 8'hB0, 8);
    checkOutput("error sticky over frame", {31'h0, ERROR_SCAN}, 32'h1);
    clrPulse();
    checkOutput("clr clears error", {31'h0, ERROR_SCAN}, 32'h0);

    // Decimal point on digit 3.
    sendDigit(0, 8'hC0, 8);
    sendDigit(1, 8'hF9, 8);
    sendDigit(2, 8'hA4, 8);
    sendDigit(3, 8'h40, 8);
    checkOutput("dp PUNTOS", {28'h0, PUNTOS}, DP ? 32'h8 : 32'h0);
    checkOutput("dp PATRON byte3", {24'h0, PATRON[31:24]}, DP ? 32'h40 : 32'hC0);
    checkOutput("dp CODIGO", {16'h0, CODIGO}, 32'h0210);

    // Reset mid-frame discards the partial capture.
    t0 = tramaCnt;
    sendDigit(0, 8'hC0, 8);
    sendDigit(1, 8'hF9, 8);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkResetValues("mid-frame reset");
    sendDigit(2, 8'hA4, 8);
    sendDigit(3, 8'hB0, 8);
    checkOutput("no frame after reset", tramaCnt, t0);

    // Timeout fires on exactly the SCAN_TIMEOUT-th cycle without a frame.
    SEGMENTOS = 8'hFF;
    DISPLAY   = 4'hF;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (TO - 1) @(negedge CLK);
    checkOutput("timeout not yet", {31'h0, ERROR_SCAN}, 32'h0);
    @(negedge CLK);
    checkOutput("timeout fires", {31'h0, ERROR_SCAN}, 32'h1);
    clrPulse();

    // Randomised scanning checked cycle by cycle against the model.
    for (int n = 0; n < 400; n++) begin
      int r, a, b;
      logic [7:0] seg;
      logic [3:0] disp;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        disp = ~((4'b1 << a) | (4'b1 << b));
      end else if (r < 20) begin
        disp = 4'hF;
      end else begin
        disp = ~(4'b1 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) < 8) seg = {1'($urandom), glyphTab[$urandom_range(0, 15)]};
      else seg = 8'($urandom);
      applyStimulus(seg, disp, $urandom_range(1, 8));
      if ($urandom_range(0, 29) == 0) clrPulse();
    end
    applyStimulus(8'hFF, 4'hF, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
